// File: rtl/loop_sequencer.sv
// ---------------------------------------------------------------------------
// loop_sequencer
//
// Iteration controller for an N-bit loadable up-counter whose carry-out (co)
// is high when the counter value is all ones. On an accepted start it loads
// the counter with 2^N - K so that co flags the last iteration. It then runs
// K iterations of a READ / EXEC / WRITE datapath cycle and pulses done.
// A start with K == 0 goes straight to DONE without touching the counter or
// the datapath.
//
// Ports
//   clk       in   1  clock, rising edge
//   rst       in   1  reset, asynchronous, active-high
//   start     in   1  begin a run; only sampled in IDLE
//   iter_cnt  in   N  iteration count K, latched when start is accepted
//   stall     in   1  freeze the current READ/EXEC/WRITE phase
//   abort     in   1  cancel the run and return to IDLE without done
//   cnt_co    in   1  counter carry-out (counter value == all ones)
//   cnt_ld    out  1  counter load strobe
//   cnt_en    out  1  counter increment strobe
//   cnt_init  out  N  counter load value, 2^N - K
//   rd_en     out  1  datapath READ strobe
//   ex_en     out  1  datapath EXEC strobe
//   wr_en     out  1  datapath WRITE strobe
//   busy      out  1  high in every state except IDLE
//   done      out  1  one-cycle completion pulse
// ---------------------------------------------------------------------------
module loop_sequencer #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] iter_cnt,
  input  logic         stall,
  input  logic         abort,
  input  logic         cnt_co,
  output logic         cnt_ld,
  output logic         cnt_en,
  output logic [N-1:0] cnt_init,
  output logic         rd_en,
  output logic         ex_en,
  output logic         wr_en,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READ  = 3'd2,
    S_EXEC  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [N-1:0] k_q;

  // Per-state flags, registered alongside the state so every output is
  // driven from a flop and only gated by the stall/abort inputs.
  logic load_q;
  logic read_q;
  logic exec_q;
  logic write_q;
  logic busy_q;
  logic done_q;

  logic phase_go;

  // Next-state logic. Abort beats stall, and stall beats the normal
  // phase advance. The counter carry is only looked at in WRITE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (iter_cnt != '0) state_d = S_LOAD;
          else                state_d = S_DONE;
        end
      end
      S_LOAD: begin
        if (abort) state_d = S_IDLE;
        else       state_d = S_READ;
      end
      S_READ: begin
        if (abort)       state_d = S_IDLE;
        else if (!stall) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (abort)       state_d = S_IDLE;
        else if (!stall) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (abort)       state_d = S_IDLE;
        else if (!stall) state_d = cnt_co ? S_DONE : S_READ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register, iteration-count latch and the registered state flags.
  // k_q is only written when a start is accepted, which keeps cnt_init
  // stable for the whole run and until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      load_q  <= 1'b0;
      read_q  <= 1'b0;
      exec_q  <= 1'b0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        k_q <= iter_cnt;
      end
      load_q  <= (state_d == S_LOAD);
      read_q  <= (state_d == S_READ);
      exec_q  <= (state_d == S_EXEC);
      write_q <= (state_d == S_WRITE);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  // A phase strobe fires only in the cycle its phase is released, so a
  // stalled phase still produces exactly one strobe per iteration.
  assign phase_go = ~stall & ~abort;

  // LOAD ignores stall but still yields to abort.
  assign cnt_ld = load_q & ~abort;
  assign rd_en  = read_q & phase_go;
  assign ex_en  = exec_q & phase_go;
  assign wr_en  = write_q & phase_go;

  // On the last WRITE the counter already reads all ones; it is not
  // advanced past that point.
  assign cnt_en = write_q & phase_go & ~cnt_co;

  assign busy = busy_q;
  assign done = done_q;

  // Two's complement of K: the counter needs K-1 increments to hit all ones.
  assign cnt_init = (~k_q) + {{(N-1){1'b0}}, 1'b1};

endmodule
